// File: rtl/instr_fetch.sv
// Instruction fetch stage: one-outstanding-request fetcher feeding a 2-entry
// {instr, pc} buffer toward decode, with redirect flush and stale-ack discard.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_started;
  logic        r_imem_req;
  logic [31:0] r_imem_addr;
  logic [31:0] r_fetch_pc;
  logic [31:0] w_fetch_pc_nxt;
  logic [31:0] w_redirect_pc;
  logic [63:0] r_fifo [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic [1:0]  w_count_nxt;
  logic        w_push;
  logic        w_pop;
  logic        w_load_addr;

  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_push        = (r_state == REQ) & imem_ack & ~redirect;
  assign w_pop         = (r_count != 2'd0) & instr_ready;

  always_comb begin
    w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
    if (redirect) w_count_nxt = 2'd0;
  end

  // fetch_pc always equals imem_addr while in REQ, so +4 advances past the acked word
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_load_addr    = 1'b0;
    if (redirect) w_fetch_pc_nxt = w_redirect_pc;
    case (r_state)
      IDLE: begin
        if (r_started && (r_count != 2'd2) && !redirect) begin
          w_state_nxt = REQ;
          w_load_addr = 1'b1;
        end
      end
      REQ: begin
        if (imem_ack) begin
          if (!redirect) w_fetch_pc_nxt = r_fetch_pc + 32'd4;
          if (w_count_nxt != 2'd2) begin
            w_state_nxt = REQ;
            w_load_addr = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (redirect) begin
          w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (imem_ack) begin
          w_state_nxt = REQ;
          w_load_addr = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // r_started delays the first request by one cycle after reset release
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_started   <= 1'b0;
      r_fetch_pc  <= RESET_PC;
      r_imem_req  <= 1'b0;
      r_imem_addr <= RESET_PC;
      r_count     <= 2'd0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_started  <= 1'b1;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_imem_req <= (w_state_nxt != IDLE);
      if (w_load_addr) r_imem_addr <= w_fetch_pc_nxt;
      r_count <= w_count_nxt;
      if (redirect) begin
        r_wr_ptr <= 1'b0;
        r_rd_ptr <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= ~r_wr_ptr;
        if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= {imem_rdata, r_imem_addr};
  end

  assign imem_req            = r_imem_req;
  assign imem_addr           = r_imem_addr;
  assign instr_valid         = (r_count != 2'd0);
  assign {instr, instr_pc}   = r_fifo[r_rd_ptr];
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized traffic, checked
// against a transaction-level model of the fetch buffer and request stream.
module tb_instr_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int n_err = 0;
  int n_chk = 0;

  // model: delivered-order queue of {instr, pc}, plus the outstanding request
  logic [63:0] q[$];
  bit          m_req;
  bit          m_drop;
  bit          m_live;
  logic [31:0] m_pc;
  logic [31:0] m_addr;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int pre;
    bit acc;
    if (!rst_n) begin
      q.delete();
      m_req  = 1'b0;
      m_drop = 1'b0;
      m_live = 1'b0;
      m_pc   = RESET_PC;
      m_addr = RESET_PC;
      return;
    end
    pre = q.size();
    acc = m_req && imem_ack;
    if (pre != 0 && instr_ready) void'(q.pop_front());
    if (acc && !m_drop && !redirect) begin
      q.push_back({imem_rdata, m_addr});
      m_pc = m_addr + 32'd4;
    end
    if (redirect) begin
      q.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
    end
    if (m_req && !acc) begin
      m_drop = m_drop || redirect;
    end else if (acc) begin
      m_drop = 1'b0;
      m_req  = (q.size() < 2);
      if (m_req) m_addr = m_pc;
    end else if (m_live && pre < 2 && !redirect) begin
      m_req  = 1'b1;
      m_addr = m_pc;
    end
    m_live = 1'b1;
  endtask

  task automatic compare();
    chk("m_req", 32'(imem_req), 32'(m_req));
    if (m_req) chk("m_addr", imem_addr, m_addr);
    chk("m_valid", 32'(instr_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("m_instr", instr, q[0][63:32]);
      chk("m_pc", instr_pc, q[0][31:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic drive(input bit r, input bit a, input bit rdy, input bit rd,
                       input logic [31:0] rpc);
    rst_n       = r;
    imem_ack    = a;
    instr_ready = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    imem_rdata  = $urandom;
  endtask

  initial begin
    drive(0, 0, 0, 0, 32'd0);
    step();
    step();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);

    // streaming with ack and ready held high
    drive(1, 1, 1, 0, 32'd0);
    step();
    chk("edge1_req", 32'(imem_req), 32'd0);
    step();
    chk("edge2_req", 32'(imem_req), 32'd1);
    chk("stream_a0", imem_addr, 32'h0);
    step();
    chk("stream_a4", imem_addr, 32'h4);
    chk("stream_pc0", instr_pc, 32'h0);
    step();
    chk("stream_a8", imem_addr, 32'h8);
    chk("stream_pc4", instr_pc, 32'h4);
    step();
    chk("stream_v", 32'(instr_valid), 32'd1);
    chk("stream_pc8", instr_pc, 32'h8);

    // fill buffer with decode stalled
    drive(0, 1, 0, 0, 32'd0);
    step();
    drive(1, 1, 0, 0, 32'd0);
    step();
    step();
    step();
    step();
    chk("full_req", 32'(imem_req), 32'd0);
    chk("full_pc", instr_pc, 32'h0);
    step();
    chk("full_hold_req", 32'(imem_req), 32'd0);
    drive(1, 1, 1, 0, 32'd0);
    step();
    chk("pop_pc4", instr_pc, 32'h4);
    drive(1, 1, 0, 0, 32'd0);
    step();
    chk("resume_req", 32'(imem_req), 32'd1);
    chk("resume_a8", imem_addr, 32'h8);

    // redirect during a stalled request
    drive(0, 0, 0, 0, 32'd0);
    step();
    drive(1, 0, 0, 0, 32'd0);
    step();
    step();
    step();
    step();
    step();
    drive(1, 0, 0, 1, 32'h103);
    step();
    chk("flush_req", 32'(imem_req), 32'd1);
    chk("flush_addr", imem_addr, 32'h0);
    drive(1, 0, 0, 0, 32'd0);
    step();
    step();
    chk("flush_hold", imem_addr, 32'h0);
    drive(1, 1, 0, 0, 32'd0);
    step();
    chk("drop_valid", 32'(instr_valid), 32'd0);
    chk("target_addr", imem_addr, 32'h100);
    drive(1, 0, 0, 0, 32'd0);
    step();
    chk("wait_valid", 32'(instr_valid), 32'd0);
    drive(1, 1, 0, 0, 32'd0);
    step();
    chk("target_pc", instr_pc, 32'h100);
    chk("target_next", imem_addr, 32'h104);

    // redirect together with ack and a transfer
    drive(1, 1, 1, 1, 32'h200);
    step();
    chk("rack_valid", 32'(instr_valid), 32'd0);
    chk("rack_addr", imem_addr, 32'h200);

    // wrap at the top of the address space
    drive(1, 0, 0, 1, 32'hFFFF_FFFF);
    step();
    chk("wrap_hold", imem_addr, 32'h200);
    drive(1, 1, 0, 0, 32'd0);
    step();
    chk("wrap_a_top", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc_top", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_a0", imem_addr, 32'h0);
    step();
    chk("wrap_full", 32'(imem_req), 32'd0);
    drive(1, 0, 1, 0, 32'd0);
    step();
    chk("wrap_pc0", instr_pc, 32'h0);

    // reset mid-request with one buffered entry
    drive(1, 0, 0, 0, 32'd0);
    step();
    chk("mid_req", 32'(imem_req), 32'd1);
    chk("mid_valid", 32'(instr_valid), 32'd1);
    drive(0, 1, 1, 1, 32'h40);
    step();
    chk("mrst_req", 32'(imem_req), 32'd0);
    chk("mrst_valid", 32'(instr_valid), 32'd0);
    chk("mrst_addr", imem_addr, RESET_PC);
    drive(1, 1, 0, 0, 32'd0);
    step();
    chk("mrst_ack_ign", 32'(instr_valid), 32'd0);
    step();
    chk("mrst_rereq", 32'(imem_req), 32'd1);

    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 7, $urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
